// File: rtl/execute_stage.sv
// execute_stage: ARM condition check, 32-bit ALU and load/store address generation into the EX/MEM register; owns NZCV.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             validIN,
    input  logic [WIDTH-1:0] Data1IN,
    input  logic [WIDTH-1:0] Data2IN,
    input  logic [WIDTH-1:0] storeDataIN,
    input  logic [4:0]       opcodeIN,
    input  logic [3:0]       condIN,
    input  logic             CPSRwriteIN,
    input  logic             linkBitIN,
    input  logic             prePostAddOffsetIN,
    input  logic             upDownOffsetIN,
    input  logic             byteOrWordIN,
    input  logic             writeBackIN,
    input  logic             loadStoreIN,
    input  logic [3:0]       rdIN,
    input  logic [3:0]       rmIN,
    output logic             validOUT,
    output logic [WIDTH-1:0] resultOUT,
    output logic [WIDTH-1:0] wbValueOUT,
    output logic [WIDTH-1:0] storeDataOUT,
    output logic [3:0]       rdOUT,
    output logic [3:0]       rmOUT,
    output logic             regWriteOUT,
    output logic             memReadOUT,
    output logic             memWriteOUT,
    output logic             baseWriteOUT,
    output logic             byteOrWordOUT,
    output logic             linkBitOUT,
    output logic [3:0]       flagsOUT
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] wb;
        logic [WIDTH-1:0] sd;
        logic [3:0]       rd;
        logic [3:0]       rm;
        logic             regw;
        logic             memr;
        logic             memw;
        logic             basew;
        logic             bw;
        logic             link;
    } ex_t;

    ex_t            ex_q, ex_d;
    logic [3:0]     flags_q, flags_d;
    logic           n, z, c, v;
    logic           pass, exec, ls, test_op, arith, cin, ovf;
    logic [3:0]     op, nzcv;
    logic [WIDTH-1:0] x, y, alu, off;
    logic [WIDTH:0] sum;

    assign {n, z, c, v} = flags_q;
    assign op      = opcodeIN[3:0];
    assign ls      = opcodeIN[4];
    assign test_op = op[3:2] == 2'b10;
    assign arith   = (~op[3] & |op[2:1]) | (op[3:1] == 3'b101);
    assign exec    = validIN & pass & ~flush;
    assign off     = upDownOffsetIN ? Data1IN + Data2IN : Data1IN - Data2IN;

    always_comb begin
        case (condIN)
            4'h0: pass = z;
            4'h1: pass = ~z;
            4'h2: pass = c;
            4'h3: pass = ~c;
            4'h4: pass = n;
            4'h5: pass = ~n;
            4'h6: pass = v;
            4'h7: pass = ~v;
            4'h8: pass = c & ~z;
            4'h9: pass = ~c | z;
            4'hA: pass = n == v;
            4'hB: pass = n != v;
            4'hC: pass = ~z & (n == v);
            4'hD: pass = z | (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Every arithmetic op is one adder: subtraction is x + ~y + carry-in.
    always_comb begin
        x   = Data1IN;
        y   = Data2IN;
        cin = 1'b0;
        case (op)
            4'h2, 4'hA: begin y = ~Data2IN; cin = 1'b1; end
            4'h3:       begin x = Data2IN; y = ~Data1IN; cin = 1'b1; end
            4'h5:       cin = c;
            4'h6:       begin y = ~Data2IN; cin = c; end
            4'h7:       begin x = Data2IN; y = ~Data1IN; cin = c; end
            default:    ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        case (op)
            4'h0, 4'h8: alu = Data1IN & Data2IN;
            4'h1, 4'h9: alu = Data1IN ^ Data2IN;
            4'hC:       alu = Data1IN | Data2IN;
            4'hD:       alu = Data2IN;
            4'hE:       alu = Data1IN & ~Data2IN;
            4'hF:       alu = ~Data2IN;
            default:    alu = sum[WIDTH-1:0];
        endcase
        ovf  = (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
        nzcv = {alu[WIDTH-1], alu == '0, arith ? sum[WIDTH] : c, arith ? ovf : v};
    end

    always_comb begin
        ex_d    = '0;
        flags_d = (exec & ~ls & (CPSRwriteIN | test_op)) ? nzcv : flags_q;
        if (exec) begin
            ex_d.valid = 1'b1;
            ex_d.sd    = storeDataIN;
            ex_d.rd    = rdIN;
            ex_d.rm    = rmIN;
            ex_d.bw    = byteOrWordIN;
            ex_d.link  = linkBitIN;
            ex_d.res   = ls ? (prePostAddOffsetIN ? off : Data1IN) : alu;
            ex_d.wb    = ls ? off : '0;
            ex_d.basew = ls & (writeBackIN | ~prePostAddOffsetIN);
            ex_d.memr  = ls & loadStoreIN;
            ex_d.memw  = ls & ~loadStoreIN;
            ex_d.regw  = ~ls & ~test_op;
        end
    end

    // Flush beats stall so a squashed instruction never lingers in the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            flags_q <= '0;
        end else if (flush | ~stall) begin
            ex_q    <= ex_d;
            flags_q <= flags_d;
        end
    end

    assign validOUT      = ex_q.valid;
    assign resultOUT     = ex_q.res;
    assign wbValueOUT    = ex_q.wb;
    assign storeDataOUT  = ex_q.sd;
    assign rdOUT         = ex_q.rd;
    assign rmOUT         = ex_q.rm;
    assign regWriteOUT   = ex_q.regw;
    assign memReadOUT    = ex_q.memr;
    assign memWriteOUT   = ex_q.memw;
    assign baseWriteOUT  = ex_q.basew;
    assign byteOrWordOUT = ex_q.bw;
    assign linkBitOUT    = ex_q.link;
    assign flagsOUT      = flags_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table, hand-written stall/flush/reset sequences and random traffic against an arithmetic model.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, validIN;
    logic [31:0] Data1IN, Data2IN, storeDataIN;
    logic [4:0]  opcodeIN;
    logic [3:0]  condIN, rdIN, rmIN;
    logic        CPSRwriteIN, linkBitIN, prePostAddOffsetIN, upDownOffsetIN;
    logic        byteOrWordIN, writeBackIN, loadStoreIN;
    logic        validOUT, regWriteOUT, memReadOUT, memWriteOUT, baseWriteOUT, byteOrWordOUT, linkBitOUT;
    logic [31:0] resultOUT, wbValueOUT, storeDataOUT;
    logic [3:0]  rdOUT, rmOUT, flagsOUT;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .validIN(validIN),
        .Data1IN(Data1IN), .Data2IN(Data2IN), .storeDataIN(storeDataIN),
        .opcodeIN(opcodeIN), .condIN(condIN), .CPSRwriteIN(CPSRwriteIN),
        .linkBitIN(linkBitIN), .prePostAddOffsetIN(prePostAddOffsetIN),
        .upDownOffsetIN(upDownOffsetIN), .byteOrWordIN(byteOrWordIN),
        .writeBackIN(writeBackIN), .loadStoreIN(loadStoreIN), .rdIN(rdIN), .rmIN(rmIN),
        .validOUT(validOUT), .resultOUT(resultOUT), .wbValueOUT(wbValueOUT),
        .storeDataOUT(storeDataOUT), .rdOUT(rdOUT), .rmOUT(rmOUT),
        .regWriteOUT(regWriteOUT), .memReadOUT(memReadOUT), .memWriteOUT(memWriteOUT),
        .baseWriteOUT(baseWriteOUT), .byteOrWordOUT(byteOrWordOUT),
        .linkBitOUT(linkBitOUT), .flagsOUT(flagsOUT)
    );

    int total = 0, bad = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] res, wb, sd;
        logic [3:0]  rd, rm;
        logic        regw, memr, memw, basew, bw, link;
    } exp_t;
    exp_t       me;
    logic [3:0] mf;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
        case (cd)
            4'h0: return f[2];
            4'h1: return !f[2];
            4'h2: return f[1];
            4'h3: return !f[1];
            4'h4: return f[3];
            4'h5: return !f[3];
            4'h6: return f[0];
            4'h7: return !f[0];
            4'h8: return f[1] && !f[2];
            4'h9: return !f[1] || f[2];
            4'hA: return f[3] == f[0];
            4'hB: return f[3] != f[0];
            4'hC: return !f[2] && f[3] == f[0];
            4'hD: return f[2] || f[3] != f[0];
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        logic [31:0] r;
        longint ua, ub, sa, sb, uu, ss, ci;
        logic arith, sub, cy, vf;
        if (reset) begin
            me = '0;
            mf = '0;
            return;
        end
        if (stall && !flush) return;
        me = '0;
        if (!(validIN && cond_ok(condIN, mf) && !flush)) return;
        me.v    = 1'b1;
        me.sd   = storeDataIN;
        me.rd   = rdIN;
        me.rm   = rmIN;
        me.bw   = byteOrWordIN;
        me.link = linkBitIN;
        if (opcodeIN[4]) begin
            r        = upDownOffsetIN ? Data1IN + Data2IN : Data1IN - Data2IN;
            me.res   = prePostAddOffsetIN ? r : Data1IN;
            me.wb    = r;
            me.basew = writeBackIN || !prePostAddOffsetIN;
            me.memr  = loadStoreIN;
            me.memw  = !loadStoreIN;
            return;
        end
        ua = {32'b0, Data1IN};
        ub = {32'b0, Data2IN};
        sa = longint'($signed(Data1IN));
        sb = longint'($signed(Data2IN));
        ci = {63'b0, mf[1]};
        arith = 1'b1; sub = 1'b0; uu = 0; ss = 0; r = '0;
        case (opcodeIN[3:0])
            4'h0, 4'h8: begin r = Data1IN & Data2IN; arith = 1'b0; end
            4'h1, 4'h9: begin r = Data1IN ^ Data2IN; arith = 1'b0; end
            4'hC:       begin r = Data1IN | Data2IN; arith = 1'b0; end
            4'hD:       begin r = Data2IN; arith = 1'b0; end
            4'hE:       begin r = Data1IN & ~Data2IN; arith = 1'b0; end
            4'hF:       begin r = ~Data2IN; arith = 1'b0; end
            4'h4, 4'hB: begin uu = ua + ub; ss = sa + sb; end
            4'h5:       begin uu = ua + ub + ci; ss = sa + sb + ci; end
            4'h2, 4'hA: begin uu = ua - ub; ss = sa - sb; sub = 1'b1; end
            4'h3:       begin uu = ub - ua; ss = sb - sa; sub = 1'b1; end
            4'h6:       begin uu = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); sub = 1'b1; end
            default:    begin uu = ub - ua - (1 - ci); ss = sb - sa - (1 - ci); sub = 1'b1; end
        endcase
        if (arith) r = uu[31:0];
        cy = sub ? (uu >= 0) : (uu > 64'sd4294967295);
        vf = ss > MAXS || ss < MINS;
        me.res  = r;
        me.regw = opcodeIN[3:2] != 2'b10;
        if (CPSRwriteIN || opcodeIN[3:2] == 2'b10)
            mf = arith ? {r[31], r == 0, cy, vf} : {r[31], r == 0, mf[1:0]};
    endtask

    task automatic check_model();
        chk("m_valid", validOUT, me.v);
        chk("m_result", resultOUT, me.res);
        chk("m_wb", wbValueOUT, me.wb);
        chk("m_store", storeDataOUT, me.sd);
        chk("m_regs", {rdOUT, rmOUT}, {me.rd, me.rm});
        chk("m_ctl", {regWriteOUT, memReadOUT, memWriteOUT, baseWriteOUT, byteOrWordOUT, linkBitOUT},
            {me.regw, me.memr, me.memw, me.basew, me.bw, me.link});
        chk("m_flags", flagsOUT, mf);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic dp(input logic [4:0] op, input logic [3:0] cd, input logic s,
                      input logic [31:0] a, input logic [31:0] b);
        validIN = 1'b1; opcodeIN = op; condIN = cd; CPSRwriteIN = s;
        Data1IN = a; Data2IN = b;
        {prePostAddOffsetIN, upDownOffsetIN, writeBackIN, loadStoreIN} = 4'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  cd;
        logic        s;
        logic [31:0] d1, d2;
        logic [3:0]  lsb;
        logic        ev;
        logic [31:0] eres, ewb;
        logic [3:0]  ectl;
        logic [3:0]  ef;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{5'h02, 4'hE, 1'b1, 32'd5, 32'd5, 4'b0000, 1'b1, 32'd0, 32'd0, 4'b1000, 4'b0110};
        tbl[1]  = '{5'h04, 4'h0, 1'b0, 32'd3, 32'd4, 4'b0000, 1'b1, 32'd7, 32'd0, 4'b1000, 4'b0110};
        tbl[2]  = '{5'h04, 4'hE, 1'b1, 32'h7FFFFFFF, 32'd1, 4'b0000, 1'b1, 32'h80000000, 32'd0, 4'b1000, 4'b1001};
        tbl[3]  = '{5'h0D, 4'h7, 1'b1, 32'd0, 32'd9, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b1001};
        tbl[4]  = '{5'h10, 4'hE, 1'b0, 32'h100, 32'd4, 4'b0001, 1'b1, 32'h100, 32'hFC, 4'b0101, 4'b1001};
        tbl[5]  = '{5'h10, 4'hE, 1'b1, 32'h200, 32'd8, 4'b1100, 1'b1, 32'h208, 32'h208, 4'b0010, 4'b1001};
        tbl[6]  = '{5'h04, 4'hF, 1'b1, 32'd1, 32'd1, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b1001};
        tbl[7]  = '{5'h0A, 4'h4, 1'b0, 32'd3, 32'd5, 4'b0000, 1'b1, 32'hFFFFFFFE, 32'd0, 4'b0000, 4'b1000};
        tbl[8]  = '{5'h02, 4'hE, 1'b1, 32'd5, 32'd3, 4'b0000, 1'b1, 32'd2, 32'd0, 4'b1000, 4'b0010};
        tbl[9]  = '{5'h0D, 4'hE, 1'b1, 32'd7, 32'd0, 4'b0000, 1'b1, 32'd0, 32'd0, 4'b1000, 4'b0110};
        tbl[10] = '{5'h05, 4'h2, 1'b0, 32'd1, 32'd1, 4'b0000, 1'b1, 32'd3, 32'd0, 4'b1000, 4'b0110};

        {reset, stall, flush, validIN, CPSRwriteIN, linkBitIN, byteOrWordIN} = 7'b1000000;
        {prePostAddOffsetIN, upDownOffsetIN, writeBackIN, loadStoreIN} = 4'b0;
        Data1IN = '0; Data2IN = '0; storeDataIN = '0;
        opcodeIN = '0; condIN = '0; rdIN = '0; rmIN = '0;
        tick();
        chk("reset_flags", flagsOUT, 4'b0000);
        chk("reset_valid", validOUT, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            dp(tbl[i].op, tbl[i].cd, tbl[i].s, tbl[i].d1, tbl[i].d2);
            {prePostAddOffsetIN, upDownOffsetIN, writeBackIN, loadStoreIN} = tbl[i].lsb;
            storeDataIN = 32'hA5000000 + i;
            rdIN = 4'(i); rmIN = 4'(15 - i);
            tick();
            chk($sformatf("t%0d_valid", i), validOUT, tbl[i].ev);
            chk($sformatf("t%0d_result", i), resultOUT, tbl[i].eres);
            chk($sformatf("t%0d_wb", i), wbValueOUT, tbl[i].ewb);
            chk($sformatf("t%0d_ctl", i), {regWriteOUT, memReadOUT, memWriteOUT, baseWriteOUT}, tbl[i].ectl);
            chk($sformatf("t%0d_flags", i), flagsOUT, tbl[i].ef);
        end

        dp(5'h04, 4'hE, 1'b1, 32'd10, 32'd20);
        tick();
        chk("pre_stall_result", resultOUT, 32'd30);
        dp(5'h0A, 4'hE, 1'b0, 32'd30, 32'd30);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_result", resultOUT, 32'd30);
            chk("stall_flags", flagsOUT, 4'b0000);
            chk("stall_regw", regWriteOUT, 1'b1);
        end
        stall = 1'b0;
        tick();
        chk("cmp_result", resultOUT, 32'd0);
        chk("cmp_regw", regWriteOUT, 1'b0);
        chk("cmp_flags", flagsOUT, 4'b0110);

        dp(5'h04, 4'hE, 1'b1, 32'h7FFFFFFF, 32'd1);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_valid", validOUT, 1'b0);
        chk("flush_regw", regWriteOUT, 1'b0);
        chk("flush_flags", flagsOUT, 4'b0110);
        stall = 1'b0; flush = 1'b0;

        dp(5'h04, 4'hE, 1'b1, 32'd1, 32'd1);
        tick();
        chk("pre_reset_result", resultOUT, 32'd2);
        dp(5'h10, 4'hE, 1'b1, 32'h40, 32'h4);
        reset = 1'b1; stall = 1'b1;
        tick();
        chk("rst_outs", {31'b0, validOUT, resultOUT, wbValueOUT, storeDataOUT, rdOUT, rmOUT,
            regWriteOUT, memReadOUT, memWriteOUT, baseWriteOUT, byteOrWordOUT, linkBitOUT} == '0, 32'd1);
        chk("rst_flags", flagsOUT, 4'b0000);
        reset = 1'b0; stall = 1'b0;

        for (int i = 0; i < 800; i++) begin
            validIN = $urandom_range(0, 7) != 0;
            opcodeIN = 5'($urandom_range(0, 31));
            condIN = 4'($urandom_range(0, 15));
            CPSRwriteIN = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++) begin
                logic [31:0] d;
                case ($urandom_range(0, 5))
                    0: d = $urandom();
                    1: d = 32'($urandom_range(0, 7));
                    2: d = 32'h7FFFFFFF;
                    3: d = 32'h80000000;
                    4: d = 32'hFFFFFFFF;
                    default: d = $urandom();
                endcase
                if (k == 0) Data1IN = d; else Data2IN = d;
            end
            storeDataIN = $urandom();
            rdIN = 4'($urandom_range(0, 15));
            rmIN = 4'($urandom_range(0, 15));
            {linkBitIN, prePostAddOffsetIN, upDownOffsetIN, byteOrWordIN, writeBackIN, loadStoreIN} = 6'($urandom_range(0, 63));
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 199) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
